// File: rtl/reg_file_sb_if.sv
// Register-file bus: write port, two read ports, scoreboard reserve and clear-sweep control.
// master drives requests; slave (the register file) returns read data and status.
interface reg_file_sb_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic              rsv;
    logic [ADDR_W-1:0] rsv_addr;
    logic              busy1;
    logic              busy2;
    logic              clr_start;
    logic              clr_busy;

    modport master (
        output we, wa, wd, ra1, ra2, rsv, rsv_addr, clr_start,
        input  rd1, rd2, busy1, busy2, clr_busy
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, rsv, rsv_addr, clr_start,
        output rd1, rd2, busy1, busy2, clr_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// NREGS x WIDTH register file with one write port, two async read ports, write-to-read bypass,
// per-register busy scoreboard and a one-register-per-cycle clear sweep.
module reg_file_sb #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          R0_ZERO = 1'b0
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    typedef enum logic {StIdle, StSweep} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              idle, sweep, wr_en, rsv_en;
    logic              hit1, hit2, rsv_hit1, rsv_hit2;

    assign idle  = (state_q == StIdle);
    assign sweep = (state_q == StSweep);

    // Register 0 silently drops writes and reserves when it is hard-wired to zero.
    assign wr_en  = idle && bus.we  && !(R0_ZERO && bus.wa == '0);
    assign rsv_en = idle && bus.rsv && !(R0_ZERO && bus.rsv_addr == '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(NREGS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reserve is applied after the write so a same-address reserve leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[bus.wa] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        if (sweep) begin
            busy_d[ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            if (wr_en) begin
                regs_q[bus.wa] <= bus.wd;
            end
            if (sweep) begin
                regs_q[ptr_q] <= '0;
            end
        end
    end

    assign hit1     = BYPASS && bus.we && (bus.wa == bus.ra1) && idle;
    assign hit2     = BYPASS && bus.we && (bus.wa == bus.ra2) && idle;
    assign rsv_hit1 = bus.rsv && (bus.rsv_addr == bus.ra1);
    assign rsv_hit2 = bus.rsv && (bus.rsv_addr == bus.ra2);

    always_comb begin
        bus.rd1   = hit1 ? bus.wd : regs_q[bus.ra1];
        bus.rd2   = hit2 ? bus.wd : regs_q[bus.ra2];
        bus.busy1 = busy_q[bus.ra1] & ~(hit1 & ~rsv_hit1);
        bus.busy2 = busy_q[bus.ra2] & ~(hit2 & ~rsv_hit2);
        if (R0_ZERO && bus.ra1 == '0) begin
            bus.rd1   = '0;
            bus.busy1 = 1'b0;
        end
        if (R0_ZERO && bus.ra2 == '0) begin
            bus.rd2   = '0;
            bus.busy2 = 1'b0;
        end
    end

    assign bus.clr_busy = sweep;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass / no-bypass with zero register) share stimulus and
// are compared against an array-based reference model, plus directed vectors and sweep sequences.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_sb_if #(.WIDTH(16), .ADDR_W(3)) bus1 ();
    reg_file_sb_if #(.WIDTH(16), .ADDR_W(3)) bus2 ();

    assign bus2.we        = bus1.we;
    assign bus2.wa        = bus1.wa;
    assign bus2.wd        = bus1.wd;
    assign bus2.ra1       = bus1.ra1;
    assign bus2.ra2       = bus1.ra2;
    assign bus2.rsv       = bus1.rsv;
    assign bus2.rsv_addr  = bus1.rsv_addr;
    assign bus2.clr_start = bus1.clr_start;

    reg_file_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    reg_file_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(1'b0), .R0_ZERO(1'b1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: register contents, busy flags, and remaining sweep cycles.
    logic [15:0] m_reg [8];
    bit          m_busy [8];
    int          sweep_left = 0;
    int          sweep_idx = 0;

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic        rsv;
        logic [2:0]  rsv_addr;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        b1;
        logic        b2;
    } tv_t;

    tv_t tv [8];
    tv_t cur;
    bit  use_tv = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input bit byp, input bit r0z, input logic [2:0] ra);
        if (r0z && ra == 3'd0) return 16'h0000;
        if (byp && bus1.we && bus1.wa == ra && sweep_left == 0) return bus1.wd;
        return m_reg[ra];
    endfunction

    function automatic logic exp_busy(input bit byp, input bit r0z, input logic [2:0] ra);
        if (r0z && ra == 3'd0) return 1'b0;
        // An in-flight bypassed write retires the pending flag unless the same cycle re-reserves.
        if (byp && bus1.we && bus1.wa == ra && sweep_left == 0 &&
            !(bus1.rsv && bus1.rsv_addr == ra)) return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic check_model();
        check("d1_rd1",   bus1.rd1,      exp_rd(1'b1, 1'b0, bus1.ra1));
        check("d1_rd2",   bus1.rd2,      exp_rd(1'b1, 1'b0, bus1.ra2));
        check("d1_busy1", 16'(bus1.busy1), 16'(exp_busy(1'b1, 1'b0, bus1.ra1)));
        check("d1_busy2", 16'(bus1.busy2), 16'(exp_busy(1'b1, 1'b0, bus1.ra2)));
        check("d1_clr_busy", 16'(bus1.clr_busy), 16'(sweep_left > 0));
        check("d2_rd1",   bus2.rd1,      exp_rd(1'b0, 1'b1, bus1.ra1));
        check("d2_rd2",   bus2.rd2,      exp_rd(1'b0, 1'b1, bus1.ra2));
        check("d2_busy1", 16'(bus2.busy1), 16'(exp_busy(1'b0, 1'b1, bus1.ra1)));
        check("d2_busy2", 16'(bus2.busy2), 16'(exp_busy(1'b0, 1'b1, bus1.ra2)));
        check("d2_clr_busy", 16'(bus2.clr_busy), 16'(sweep_left > 0));
    endtask

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]  = 16'h0000;
                m_busy[i] = 1'b0;
            end
            sweep_left = 0;
        end else if (sweep_left > 0) begin
            m_reg[sweep_idx]  = 16'h0000;
            m_busy[sweep_idx] = 1'b0;
            sweep_idx++;
            sweep_left--;
        end else begin
            if (bus1.we) begin
                m_reg[bus1.wa]  = bus1.wd;
                m_busy[bus1.wa] = 1'b0;
            end
            if (bus1.rsv) m_busy[bus1.rsv_addr] = 1'b1;
            if (bus1.clr_start) begin
                sweep_left = 8;
                sweep_idx  = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        if (use_tv) begin
            check("tv_rd1",   bus1.rd1, cur.rd1);
            check("tv_rd2",   bus1.rd2, cur.rd2);
            check("tv_busy1", 16'(bus1.busy1), 16'(cur.b1));
            check("tv_busy2", 16'(bus1.busy2), 16'(cur.b2));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus1.we = 1'b0;  bus1.wa = 3'd0;  bus1.wd = 16'h0000;
        bus1.ra1 = 3'd0; bus1.ra2 = 3'd0; bus1.rsv = 1'b0;
        bus1.rsv_addr = 3'd0; bus1.clr_start = 1'b0;
    endtask

    task automatic fill_regs();
        for (int i = 0; i < 8; i++) begin
            bus1.we = 1'b1;
            bus1.wa = 3'(i);
            bus1.wd = 16'(16'h1111 * i);
            tick();
        end
        bus1.we = 1'b0;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            bus1.ra1 = 3'(i);
            bus1.ra2 = 3'(7 - i);
            #1;
            check(name, bus1.rd1, 16'h0000);
            check(name, 16'(bus1.busy1), 16'h0000);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b0, 3'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        tv[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
        tv[2] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[3] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tv[4] = '{1'b1, 3'd5, 16'h1234, 3'd3, 3'd5, 1'b0, 3'd0, 16'hBEEF, 16'h1234, 1'b0, 1'b0};
        tv[5] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0};
        tv[6] = '{1'b1, 3'd2, 16'h00AA, 3'd2, 3'd5, 1'b1, 3'd2, 16'h00AA, 16'h1234, 1'b0, 1'b0};
        tv[7] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b0, 3'd0, 16'h00AA, 16'hBEEF, 1'b1, 1'b0};

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0;
        check("reset_clr_busy", 16'(bus1.clr_busy), 16'h0000);
        read_all_zero("reset_read");

        foreach (tv[k]) begin
            cur = tv[k];
            bus1.we = cur.we;   bus1.wa = cur.wa;   bus1.wd = cur.wd;
            bus1.ra1 = cur.ra1; bus1.ra2 = cur.ra2;
            bus1.rsv = cur.rsv; bus1.rsv_addr = cur.rsv_addr;
            use_tv = 1'b1;
            tick();
        end
        use_tv = 1'b0;
        idle_inputs();

        // Sweep with writes attempted throughout; they must all be dropped.
        fill_regs();
        bus1.rsv = 1'b1; bus1.rsv_addr = 3'd6;
        tick();
        bus1.rsv = 1'b0;
        bus1.clr_start = 1'b1;
        tick();
        bus1.clr_start = 1'b0;
        n = 0;
        while (bus1.clr_busy === 1'b1 && n < 20) begin
            bus1.we = 1'b1; bus1.wa = 3'(n); bus1.wd = 16'hFFFF;
            bus1.ra1 = 3'(n); bus1.ra2 = 3'(7 - n);
            tick();
            n++;
        end
        check("sweep_len", 16'(n), 16'd8);
        idle_inputs();
        read_all_zero("after_sweep");

        // Reset landing in sweep cycle 3 aborts the sweep and clears everything.
        fill_regs();
        bus1.clr_start = 1'b1;
        tick();
        bus1.clr_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("sweep_active", 16'(bus1.clr_busy), 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_clr_busy", 16'(bus1.clr_busy), 16'h0000);
        read_all_zero("after_abort");

        // Zero-register instance ignores writes to r0.
        bus1.we = 1'b1; bus1.wa = 3'd0; bus1.wd = 16'hFFFF; bus1.ra1 = 3'd0;
        #1;
        check("r0_same_cycle", bus2.rd1, 16'h0000);
        tick();
        bus1.we = 1'b0;
        #1;
        check("r0_after", bus2.rd1, 16'h0000);
        check("r0_plain", bus1.rd1, 16'hFFFF);
        tick();

        for (int i = 0; i < 400; i++) begin
            bus1.we        = 1'($urandom_range(0, 1));
            bus1.wa        = 3'($urandom_range(0, 7));
            bus1.wd        = 16'($urandom);
            bus1.ra1       = 3'($urandom_range(0, 7));
            bus1.ra2       = 3'($urandom_range(0, 7));
            bus1.rsv       = 1'($urandom_range(0, 1));
            bus1.rsv_addr  = 3'($urandom_range(0, 7));
            bus1.clr_start = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
